// File: rtl/sram_req_ctrl_pkg.sv
// Shared widths and the request bundle for the gf180 512x8 SRAM controller.
package sram_req_pkg;

    localparam int SRAM_ADDR_W = 9;
    localparam int SRAM_DATA_W = 8;

    typedef struct packed {
        logic                   we;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] wdata;
        logic [SRAM_DATA_W-1:0] wmask;
    } sram_req_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small synchronous FIFO buffering SRAM read data until the consumer takes it.
module sram_rsp_fifo #(
    parameter  int DEPTH = 3,
    parameter  int WIDTH = 8,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, do_push, do_pop;

    assign empty_o    = (count_q == '0);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign do_pop     = pop_i & ~empty_o;
    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign do_push    = push_i & (~full | do_pop);
    assign pop_data_o = mem_q[rd_q];
    assign count_o    = count_q;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (do_push) begin
            wr_d = (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_d = (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_data_i;
            end
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(push_i && full && !pop_i));

endmodule

// File: rtl/sram_req_ctrl.sv
// Request/response front end for one gf180 512x8 SRAM macro: pin polarity,
// read-latency tracking and in-order buffering of read data.
module sram_req_ctrl
    import sram_req_pkg::*;
#(
    parameter int ADDR_W    = SRAM_ADDR_W,
    parameter int DATA_W    = SRAM_DATA_W,
    parameter int RSP_DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W-1:0] req_wmask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              sram_cen,
    output logic              sram_gwen,
    output logic [DATA_W-1:0] sram_wen,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    sram_req_t         req;
    logic              fire;
    logic              inflight_q, inflight_d;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [OCC_W-1:0]  occupancy;

    assign req  = '{we: req_we, addr: req_addr, wdata: req_wdata, wmask: req_wmask};
    assign fire = req_valid & req_ready;

    // Reserve a FIFO slot for every read still travelling through the macro,
    // so its data always has somewhere to land.
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign req_ready = ~rst & (occupancy < OCC_W'(RSP_DEPTH));

    assign inflight_d = fire & ~req.we;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    always_comb begin
        sram_cen  = ~fire;
        sram_gwen = ~(fire & req.we);
        sram_wen  = fire ? ~req.wmask : '1;
        sram_a    = req.addr;
        sram_d    = req.wdata;
    end

    sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_W)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i (sram_q),
        .pop_i       (rsp_ready),
        .pop_data_o  (rsp_rdata),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign rsp_valid = ~fifo_empty;

endmodule
